muldiv_scheduler: RTL and testbench
===================================

// Module: muldiv_scheduler
// PURPOSE
//  Sequences the shared multi-cycle mult and div units for the execute stage.
//  Latches one HI/LO-class op and its operands, then drives the chosen unit until done.
//  Applies sign pre/post-correction and the MADD/MSUB accumulate, then holds the result until the pipeline advances.
//  Raises the execute-stage stall while busy and cancels cleanly on flush.
// PARAMETERS
//  W       32  operand width; results are 2*W (HI:LO)
//  CNT_W   6   width of the busy-cycle counter (perf/debug; saturating)
// PORTS
//  clk          in   1     clock
//  reset        in   1     async active-high reset
//  req_valid    in   1     E stage holds a mult/div-class op (held high while stalled)
//  req_op       in   4     muldiv_op_t: MULT,MULTU,DIV,DIVU,MUL,MADD,MADDU,MSUB,MSUBU
//  req_a,req_b  in   W     rs / rt values
//  req_acc      in   2W    current {HI,LO} (MADD/MSUB family)
//  flush        in   1     exception/redirect: kill the in-flight op
//  advance      in   1     E->M register loads this cycle
//  stall        out  1     hold PC/F/D/E (pcf4 source)
//  res_valid    out  1     result registers valid
//  res_hi,res_lo out W     result; MUL puts the product low word in res_lo
//  res_hilo_we  out  1     write HI/LO (0 for MUL)
//  res_gpr_we   out  1     write GPR (MUL only)
//  mul_valid    out  1     level request to mult unit
//  mul_a,mul_b  out  W     unsigned magnitudes to mult
//  mul_done     in   1     mult done
//  mul_c        in   2W    unsigned product
//  div_valid    out  1     level request to div unit
//  div_a,div_b  out  W     unsigned magnitudes to div
//  div_done     in   1     div done
//  div_c        in   2W    {remainder, quotient}, unsigned
//  busy_cycles  out  CNT_W cycles spent in MUL/DIV for the last op (saturates)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including res_* and busy_cycles.
//  States: IDLE, MUL, DIV, DONE.
//   IDLE: on req_valid & ~flush, latch op, |a|, |b|, sign_a, sign_b, acc.
//     Unsigned ops and magnitudes: operand passed unchanged.
//     Signed ops: negative operand is two's-negated.
//     Div op with b==0: go to DONE with hi=a, lo={W{1}}; the div unit is never started.
//     Other div ops go to DIV; mult-family ops go to MUL.
//   MUL/DIV: unit valid=1, driven only from latched regs; busy_cycles increments.
//     On done: latch the corrected result, go to DONE. Unit valid drops in DONE.
//   DONE: res_valid=1; advance -> IDLE; otherwise hold.
//  Result correction:
//   Signed MULT/MUL/MADD/MSUB: product negated if sign_a^sign_b.
//   MADD/MADDU: acc + p, mod 2^2W.
//   MSUB/MSUBU: acc - p, mod 2^2W.
//   DIV: lo = quotient, negated if sign_a^sign_b; hi = remainder, negated if sign_a.
//   DIVU: taken as-is; hi = remainder, lo = quotient.
//   MUL: res_lo = product low word, res_hi = 0.
//  stall = req_valid & (state != DONE) & ~flush, combinational.
//   Stall is never asserted in the cycle res_valid is 1.
//  Latency: accept at edge T; unit valid from T+1.
//   done sampled at edge D; res_valid from D+1. Div-by-0 gives res_valid at T+1.
//  flush (any state): next state IDLE, res_valid=0 next cycle, unit valid drops next cycle.
//   Units treat valid low as abort/restart. A late done after flush is ignored.
//  flush and done in the same cycle: flush wins.
//  advance in IDLE/MUL/DIV: ignored.
//  A new op in the cycle after DONE->IDLE is accepted normally (back-to-back).
//  busy_cycles clears on accept; saturates at 2^CNT_W-1.
// STRUCTURE
//  pipeline.svh/pkg: muldiv_op_t enum, muldiv_state_t enum, is_div(), is_signed() helpers.
//  One combinational sub-module, muldiv_fixup: sign/accumulate post-correction.
//   Reused for the div-by-0 path.
// TESTING
//  1. MULT a=-3, b=7 (mul_done 3 cycles after valid)
//     -> stall for 4 cycles; then res_hi=0xFFFFFFFF, res_lo=0xFFFFFFEB, hilo_we=1.
//  2. DIV a=-7, b=2
//     -> div_a=7, div_b=2; res_lo=0xFFFFFFFD (-3), res_hi=0xFFFFFFFF (-1).
//  3. DIVU a=5, b=0
//     -> div_valid never rises; res_valid at T+1: hi=5, lo=0xFFFFFFFF.
//  4. MADDU acc=0xFFFFFFFF_FFFFFFFF, a=1, b=1 -> {hi,lo}=0 (wraps).
//     MUL a=b=0x10000 -> lo=0, gpr_we=1, hilo_we=0.
//  5. flush mid-DIV with div_done in the same cycle
//     -> IDLE, res_valid stays 0, stall 0; next req accepted.
//  6. DONE with advance=0 for 3 cycles -> result held, stall 0;
//     advance=1 then immediate MULTU -> accepted next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the mult/div scheduler.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MUL   = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational post-correction: sign restore, MADD/MSUB accumulate,
// MUL low-word selection and the divide-by-zero result pattern.
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  muldiv_op_t       op,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             div_zero,
    input  logic [2*W-1:0]   raw,
    input  logic [2*W-1:0]   acc,
    output logic [W-1:0]     hi,
    output logic [W-1:0]     lo,
    output logic             hilo_we,
    output logic             gpr_we
);

    logic [2*W-1:0] prod;
    logic [2*W-1:0] res;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;

    always_comb begin
        prod    = (is_signed(op) && (sign_a ^ sign_b)) ? -raw : raw;
        quo     = raw[W-1:0];
        rem     = raw[2*W-1:W];
        res     = prod;
        hilo_we = 1'b1;
        gpr_we  = 1'b0;
        case (op)
            OP_MADD, OP_MADDU: res = acc + prod;
            OP_MSUB, OP_MSUBU: res = acc - prod;
            OP_MUL: begin
                res     = {{W{1'b0}}, prod[W-1:0]};
                hilo_we = 1'b0;
                gpr_we  = 1'b1;
            end
            // remainder follows the dividend's sign, quotient the sign product
            OP_DIV:  res = {(sign_a ? -rem : rem), ((sign_a ^ sign_b) ? -quo : quo)};
            OP_DIVU: res = raw;
            default: res = prod;
        endcase
        if (div_zero) begin
            res[W-1:0] = {W{1'b1}};
        end
    end

    assign hi = res[2*W-1:W];
    assign lo = res[W-1:0];

endmodule

// File: rtl/muldiv_scheduler.sv
// Execute-stage sequencer for the shared multi-cycle mult and div units:
// latches one HI/LO-class op, runs the unit, corrects and holds the result.
module muldiv_scheduler
    import muldiv_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  muldiv_op_t       req_op,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [2*W-1:0]   req_acc,
    input  logic             flush,
    input  logic             advance,
    output logic             stall,
    output logic             res_valid,
    output logic [W-1:0]     res_hi,
    output logic [W-1:0]     res_lo,
    output logic             res_hilo_we,
    output logic             res_gpr_we,
    output logic             mul_valid,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_done,
    input  logic [2*W-1:0]   mul_c,
    output logic             div_valid,
    output logic [W-1:0]     div_a,
    output logic [W-1:0]     div_b,
    input  logic             div_done,
    input  logic [2*W-1:0]   div_c,
    output logic [CNT_W-1:0] busy_cycles
);

    muldiv_state_t  state;
    muldiv_op_t     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           sa_q;
    logic           sb_q;
    logic [2*W-1:0] acc_q;

    logic           sgn_a;
    logic           sgn_b;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic           div_zero;
    logic           unit_done;

    muldiv_op_t     fix_op;
    logic           fix_sa;
    logic           fix_sb;
    logic           fix_dz;
    logic [2*W-1:0] fix_raw;
    logic [2*W-1:0] fix_acc;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;
    logic           fix_hilo_we;
    logic           fix_gpr_we;

    always_comb begin
        sgn_a    = is_signed(req_op) & req_a[W-1];
        sgn_b    = is_signed(req_op) & req_b[W-1];
        abs_a    = sgn_a ? -req_a : req_a;
        abs_b    = sgn_b ? -req_b : req_b;
        div_zero = is_div(req_op) && (req_b == '0);
    end

    // In IDLE the fixup serves the divide-by-zero path straight from the request
    always_comb begin
        fix_op  = op_q;
        fix_sa  = sa_q;
        fix_sb  = sb_q;
        fix_dz  = 1'b0;
        fix_acc = acc_q;
        fix_raw = mul_c;
        case (state)
            S_IDLE: begin
                fix_op  = req_op;
                fix_sa  = sgn_a;
                fix_sb  = sgn_b;
                fix_dz  = 1'b1;
                fix_acc = req_acc;
                fix_raw = {abs_a, {W{1'b1}}};
            end
            S_DIV:   fix_raw = div_c;
            default: fix_raw = mul_c;
        endcase
    end

    muldiv_fixup #(.W(W)) u_fixup (
        .op       (fix_op),
        .sign_a   (fix_sa),
        .sign_b   (fix_sb),
        .div_zero (fix_dz),
        .raw      (fix_raw),
        .acc      (fix_acc),
        .hi       (fix_hi),
        .lo       (fix_lo),
        .hilo_we  (fix_hilo_we),
        .gpr_we   (fix_gpr_we)
    );

    assign unit_done = ((state == S_MUL) && mul_done) || ((state == S_DIV) && div_done);
    assign stall     = req_valid && (state != S_DONE) && !flush;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign div_a     = a_q;
    assign div_b     = b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_MULT;
            a_q         <= '0;
            b_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            acc_q       <= '0;
            res_valid   <= 1'b0;
            res_hi      <= '0;
            res_lo      <= '0;
            res_hilo_we <= 1'b0;
            res_gpr_we  <= 1'b0;
            mul_valid   <= 1'b0;
            div_valid   <= 1'b0;
            busy_cycles <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            mul_valid <= 1'b0;
            div_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        a_q         <= abs_a;
                        b_q         <= abs_b;
                        sa_q        <= sgn_a;
                        sb_q        <= sgn_b;
                        acc_q       <= req_acc;
                        busy_cycles <= '0;
                        if (div_zero) begin
                            state       <= S_DONE;
                            res_valid   <= 1'b1;
                            res_hi      <= fix_hi;
                            res_lo      <= fix_lo;
                            res_hilo_we <= fix_hilo_we;
                            res_gpr_we  <= fix_gpr_we;
                        end else if (is_div(req_op)) begin
                            state     <= S_DIV;
                            div_valid <= 1'b1;
                        end else begin
                            state     <= S_MUL;
                            mul_valid <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (busy_cycles != {CNT_W{1'b1}}) begin
                        busy_cycles <= busy_cycles + CNT_W'(1);
                    end
                    if (unit_done) begin
                        state       <= S_DONE;
                        res_valid   <= 1'b1;
                        res_hi      <= fix_hi;
                        res_lo      <= fix_lo;
                        res_hilo_we <= fix_hilo_we;
                        res_gpr_we  <= fix_gpr_we;
                        mul_valid   <= 1'b0;
                        div_valid   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (advance) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler with simple latency-programmable mult/div unit models.
module tb_muldiv_scheduler;
    import muldiv_pkg::*;

    localparam int W     = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    muldiv_op_t       req_op;
    logic [W-1:0]     req_a, req_b;
    logic [2*W-1:0]   req_acc;
    logic             flush, advance;
    logic             stall, res_valid, res_hilo_we, res_gpr_we;
    logic [W-1:0]     res_hi, res_lo;
    logic             mul_valid, mul_done, div_valid, div_done;
    logic [W-1:0]     mul_a, mul_b, div_a, div_b;
    logic [2*W-1:0]   mul_c, div_c;
    logic [CNT_W-1:0] busy_cycles;

    int vector_count    = 0;
    int miscompare_count = 0;
    int mul_lat = 3;
    int div_lat = 5;
    int mul_cnt = 0;
    int div_cnt = 0;
    logic div_force = 1'b0;

    int stalls, first_valid;
    bit saw_mul, saw_div;

    always #5 clk = ~clk;

    muldiv_scheduler #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_acc(req_acc), .flush(flush),
        .advance(advance), .stall(stall), .res_valid(res_valid),
        .res_hi(res_hi), .res_lo(res_lo), .res_hilo_we(res_hilo_we),
        .res_gpr_we(res_gpr_we), .mul_valid(mul_valid), .mul_a(mul_a),
        .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c),
        .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c), .busy_cycles(busy_cycles)
    );

    // Unit models: done after a programmable number of valid cycles, restart when valid drops
    always @(posedge clk) begin
        mul_cnt <= mul_valid ? mul_cnt + 1 : 0;
        div_cnt <= div_valid ? div_cnt + 1 : 0;
    end
    assign mul_done = mul_valid && (mul_cnt == mul_lat - 1);
    assign mul_c    = {32'b0, mul_a} * {32'b0, mul_b};
    assign div_done = (div_valid && (div_cnt == div_lat - 1)) || div_force;
    assign div_c    = (div_b == '0) ? 64'd0 : {div_a % div_b, div_a / div_b};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Presents one op and waits (bounded) until res_valid, recording stall and unit activity
    task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] acc);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_acc = acc; advance = 1'b0;
        stalls = 0; first_valid = -1; saw_mul = 0; saw_div = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if ((mul_valid || div_valid) && first_valid < 0) first_valid = i;
            saw_mul |= mul_valid;
            saw_div |= div_valid;
            if (res_valid) break;
            if (stall) stalls++;
            @(negedge clk);
        end
    endtask

    task automatic expectResult(input string tag, input logic [63:0] hilo, input bit hilo_we, input bit gpr_we);
        checkOutput({tag, "_valid"}, res_valid, 1'b1);
        checkOutput({tag, "_hilo"}, {res_hi, res_lo}, hilo);
        checkOutput({tag, "_hilo_we"}, res_hilo_we, hilo_we);
        checkOutput({tag, "_gpr_we"}, res_gpr_we, gpr_we);
        checkOutput({tag, "_stall_done"}, stall, 1'b0);
    endtask

    task automatic releaseResult(input string tag);
        req_valid = 1'b0; advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        #1;
        checkOutput({tag, "_released"}, res_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = OP_MULT; req_a = '0; req_b = '0;
        req_acc = '0; flush = 1'b0; advance = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_outputs", {res_valid, res_hilo_we, res_gpr_we, mul_valid, div_valid, stall}, 6'b0);
        checkOutput("rst_result", {res_hi, res_lo}, 64'd0);
        checkOutput("rst_busy", busy_cycles, 6'd0);
        reset = 1'b0;
        @(negedge clk);

        // MULT -3 * 7
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 64'd0);
        expectResult("mult", 64'hFFFFFFFF_FFFFFFEB, 1'b1, 1'b0);
        checkOutput("mult_stalls", stalls, 4);
        checkOutput("mult_first_valid", first_valid, 1);
        checkOutput("mult_mags", {mul_a, mul_b}, {32'd3, 32'd7});
        checkOutput("mult_busy", busy_cycles, 6'd3);
        checkOutput("mult_unit_off", mul_valid, 1'b0);
        releaseResult("mult");

        // DIV -7 / 2
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0);
        expectResult("div", 64'hFFFFFFFF_FFFFFFFD, 1'b1, 1'b0);
        checkOutput("div_mags", {div_a, div_b}, {32'd7, 32'd2});
        checkOutput("div_busy", busy_cycles, 6'd5);
        checkOutput("div_no_mul", saw_mul, 1'b0);
        releaseResult("div");

        // DIV 7 / -2
        applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE, 64'd0);
        expectResult("div_nb", 64'h00000001_FFFFFFFD, 1'b1, 1'b0);
        releaseResult("div_nb");

        // DIVU 5 / 0 and DIV -5 / 0
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 64'd0);
        expectResult("divu0", 64'h00000005_FFFFFFFF, 1'b1, 1'b0);
        checkOutput("divu0_no_div", saw_div, 1'b0);
        checkOutput("divu0_stalls", stalls, 1);
        checkOutput("divu0_busy", busy_cycles, 6'd0);
        releaseResult("divu0");
        applyStimulus(OP_DIV, 32'hFFFFFFFB, 32'd0, 64'd0);
        expectResult("div0", 64'hFFFFFFFB_FFFFFFFF, 1'b1, 1'b0);
        checkOutput("div0_no_div", saw_div, 1'b0);
        releaseResult("div0");

        // Accumulate family and MUL
        applyStimulus(OP_MADDU, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF);
        expectResult("maddu", 64'd0, 1'b1, 1'b0);
        releaseResult("maddu");
        applyStimulus(OP_MADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
        expectResult("madd", 64'd1, 1'b1, 1'b0);
        releaseResult("madd");
        applyStimulus(OP_MSUB, 32'hFFFFFFFE, 32'd3, 64'd10);
        expectResult("msub", 64'd16, 1'b1, 1'b0);
        releaseResult("msub");
        applyStimulus(OP_MSUBU, 32'd1, 32'd1, 64'd0);
        expectResult("msubu", 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0);
        releaseResult("msubu");
        applyStimulus(OP_MUL, 32'h00010000, 32'h00010000, 64'd0);
        expectResult("mul", 64'd0, 1'b0, 1'b1);
        releaseResult("mul");

        // Flush with div_done in the same cycle, then a late done while idle
        div_lat = 10;
        req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7; req_acc = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("flush_div_running", div_valid, 1'b1);
        flush = 1'b1; div_force = 1'b1;
        #1;
        checkOutput("flush_stall", stall, 1'b0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        checkOutput("flush_state", {res_valid, div_valid, stall}, 3'b000);
        @(negedge clk);
        div_force = 1'b0;
        #1;
        checkOutput("flush_late_done", res_valid, 1'b0);
        div_lat = 5;
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 64'd0);
        expectResult("post_flush", {32'd2, 32'd14}, 1'b1, 1'b0);
        checkOutput("post_flush_first_valid", first_valid, 1);
        releaseResult("post_flush");

        // Hold in DONE without advance, then back-to-back MULTU
        applyStimulus(OP_MULT, 32'h80000000, 32'd1, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            expectResult("hold", 64'hFFFFFFFF_80000000, 1'b1, 1'b0);
        end
        checkOutput("hold_mag", mul_a, 32'h80000000);
        req_valid = 1'b0; advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
        expectResult("b2b", 64'hFFFFFFFE_00000001, 1'b1, 1'b0);
        checkOutput("b2b_first_valid", first_valid, 1);
        checkOutput("b2b_stalls", stalls, 4);
        releaseResult("b2b");

        // Long divide saturates the busy counter
        div_lat = 70;
        applyStimulus(OP_DIVU, 32'd1000, 32'd10, 64'd0);
        expectResult("sat", 64'd100, 1'b1, 1'b0);
        checkOutput("sat_busy", busy_cycles, 6'd63);
        releaseResult("sat");

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
